control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 21 ++
 rtl/control_sequencer.sv | 97 +++++++++
 tb/tb_control_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/condition inputs and all control strobes of the sequencer.
interface control_sequencer_if;
  logic [31:0] ir;
  logic con;
  logic pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, inport_out, c_out, ba_out, r_out;
  logic pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, r_in;
  logic gra, grb, grc, read, write, run;
  logic [3:0] alu_op;
  modport master (
    output ir, con,
    input pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, inport_out, c_out, ba_out, r_out,
    input pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, r_in,
    input gra, grb, grc, read, write, run, alu_op
  );
  modport slave (
    input ir, con,
    output pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, inport_out, c_out, ba_out, r_out,
    output pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, r_in,
    output gra, grb, grc, read, write, run, alu_op
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: step sequencer (RST, T0..T7, HALT) with combinational strobe decode of step and opcode.
module control_sequencer (
  input logic clk,
  input logic rst_n,
  control_sequencer_if.slave bus
);
  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_AND = 5'b01001, OP_OR = 5'b01010, OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI = 5'b01101, OP_BR = 5'b10010, OP_JR = 5'b10011;
  localparam logic [4:0] OP_IN = 5'b10101, OP_OUT = 5'b10110, OP_MFHI = 5'b10111, OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;
  state_t state;
  logic [4:0] op;
  logic alu_r, alu_i, is_ldi, is_ld, is_st, is_br, is_halt;
  logic [3:0] alu_sel, alu_op;
  logic pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, inport_out, c_out, ba_out, r_out;
  logic pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, r_in;
  logic gra, grb, grc, read, write;
  assign op = bus.ir[31:27];
  assign alu_r = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign alu_i = op inside {OP_ADDI, OP_ANDI, OP_ORI};
  assign is_ldi = op == OP_LDI;
  assign is_ld = op == OP_LD;
  assign is_st = op == OP_ST;
  assign is_br = op == OP_BR;
  assign is_halt = op == OP_HALT;
  assign alu_sel = op == OP_SUB ? 4'd1 : op inside {OP_AND, OP_ANDI} ? 4'd2 : op inside {OP_OR, OP_ORI} ? 4'd3 : 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RST;
    else
      case (state)
        RST: state <= T0;
        T0: state <= T1;
        T1: state <= T2;
        T2: state <= T3;
        T3: state <= is_halt ? HALT : (alu_r | alu_i | is_ldi | is_ld | is_st | is_br) ? T4 : T0;
        T4: state <= T5;
        T5: state <= (is_ld | is_st | is_br) ? T6 : T0;
        T6: state <= is_br ? T0 : T7;
        T7: state <= T0;
        HALT: state <= HALT;
        default: state <= RST;
      endcase
  // Unknown opcodes fall through every branch below, so they behave as nop.
  always_comb begin
    {pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, inport_out, c_out, ba_out, r_out} = '0;
    {pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, r_in} = '0;
    {gra, grb, grc, read, write} = '0;
    alu_op = 4'd0;
    case (state)
      T0: {pc_out, mar_in, inc_pc, z_in} = 4'hf;
      T1: {zlo_out, pc_in, read, mdr_in} = 4'hf;
      T2: {mdr_out, ir_in} = 2'b11;
      T3:
        if (alu_r | alu_i) {grb, r_out, y_in} = 3'b111;
        else if (is_ldi | is_ld | is_st) {grb, ba_out, y_in} = 3'b111;
        else if (is_br) {gra, r_out, con_in} = 3'b111;
        else if (op == OP_JR) {gra, r_out, pc_in} = 3'b111;
        else if (op == OP_IN) {inport_out, gra, r_in} = 3'b111;
        else if (op == OP_OUT) {gra, r_out, outport_in} = 3'b111;
        else if (op == OP_MFHI) {hi_out, gra, r_in} = 3'b111;
        else if (op == OP_MFLO) {lo_out, gra, r_in} = 3'b111;
      T4:
        if (alu_r) begin
          {grc, r_out, z_in} = 3'b111;
          alu_op = alu_sel;
        end else if (alu_i | is_ldi | is_ld | is_st) begin
          {c_out, z_in} = 2'b11;
          alu_op = alu_sel;
        end else if (is_br) {pc_out, y_in} = 2'b11;
      T5:
        if (alu_r | alu_i | is_ldi) {zlo_out, gra, r_in} = 3'b111;
        else if (is_ld | is_st) {zlo_out, mar_in} = 2'b11;
        else if (is_br) {c_out, z_in} = 2'b11;
      T6:
        if (is_ld) {read, mdr_in} = 2'b11;
        else if (is_st) {gra, r_out, mdr_in} = 3'b111;
        else if (is_br) begin
          zlo_out = 1'b1;
          pc_in = bus.con;
        end
      T7:
        if (is_ld) {mdr_out, gra, r_in} = 3'b111;
        else if (is_st) write = 1'b1;
      default: ;
    endcase
  end
  assign {bus.pc_out, bus.mdr_out, bus.zhi_out, bus.zlo_out, bus.hi_out, bus.lo_out, bus.inport_out,
          bus.c_out, bus.ba_out, bus.r_out} =
         {pc_out, mdr_out, zhi_out, zlo_out, hi_out, lo_out, inport_out, c_out, ba_out, r_out};
  assign {bus.pc_in, bus.inc_pc, bus.mar_in, bus.mdr_in, bus.ir_in, bus.y_in, bus.z_in, bus.hi_in,
          bus.lo_in, bus.con_in, bus.outport_in, bus.r_in} =
         {pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, outport_in, r_in};
  assign {bus.gra, bus.grb, bus.grc, bus.read, bus.write, bus.alu_op} = {gra, grb, grc, read, write, alu_op};
  assign bus.run = !(state inside {RST, HALT});
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench; a per-opcode step-list model predicts every cycle's strobes.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  control_sequencer_if bus();
  control_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_AND = 5'b01001, OP_OR = 5'b01010, OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI = 5'b01101, OP_BR = 5'b10010, OP_JR = 5'b10011;
  localparam logic [4:0] OP_IN = 5'b10101, OP_OUT = 5'b10110, OP_MFHI = 5'b10111, OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;
  localparam logic [31:0] PCO = 32'd1 << 0, MDRO = 32'd1 << 1, ZLO = 32'd1 << 3;
  localparam logic [31:0] HIO = 32'd1 << 4, LOO = 32'd1 << 5, INPO = 32'd1 << 6, CO = 32'd1 << 7;
  localparam logic [31:0] BAO = 32'd1 << 8, RO = 32'd1 << 9, PCI = 32'd1 << 10, INC = 32'd1 << 11;
  localparam logic [31:0] MARI = 32'd1 << 12, MDRI = 32'd1 << 13, IRI = 32'd1 << 14, YI = 32'd1 << 15;
  localparam logic [31:0] ZI = 32'd1 << 16, CONI = 32'd1 << 19, OUTI = 32'd1 << 20, RI = 32'd1 << 21;
  localparam logic [31:0] GRC = 32'd1 << 22, GRB = 32'd1 << 23, GRA = 32'd1 << 24, WR = 32'd1 << 25;
  localparam logic [31:0] RD = 32'd1 << 26, RUN = 32'd1 << 31;
  logic [31:0] obs, e;
  logic [31:0] sb[$];
  logic [31:0] seq[$];
  int vec = 0, errs = 0;
  assign obs = {bus.run, bus.alu_op, bus.read, bus.write, bus.gra, bus.grb, bus.grc,
                bus.r_in, bus.outport_in, bus.con_in, bus.lo_in, bus.hi_in, bus.z_in, bus.y_in, bus.ir_in,
                bus.mdr_in, bus.mar_in, bus.inc_pc, bus.pc_in,
                bus.r_out, bus.ba_out, bus.c_out, bus.inport_out, bus.lo_out, bus.hi_out, bus.zlo_out,
                bus.zhi_out, bus.mdr_out, bus.pc_out};
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  function automatic logic [31:0] aw(input logic [4:0] op);
    int code;
    code = (op == OP_SUB) ? 1 : (op == OP_AND || op == OP_ANDI) ? 2 : (op == OP_OR || op == OP_ORI) ? 3 : 0;
    return 32'(code) << 27;
  endfunction
  // Fills seq with the expected word of every step from T0 to the last execute step.
  task automatic build(input logic [4:0] op, input logic c);
    logic [31:0] s[$];
    seq = {RUN | PCO | MARI | INC | ZI, RUN | ZLO | PCI | RD | MDRI, RUN | MDRO | IRI};
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: s = {GRB | RO | YI, GRC | RO | ZI | aw(op), ZLO | GRA | RI};
      OP_ADDI, OP_ANDI, OP_ORI: s = {GRB | RO | YI, CO | ZI | aw(op), ZLO | GRA | RI};
      OP_LDI: s = {GRB | BAO | YI, CO | ZI, ZLO | GRA | RI};
      OP_LD: s = {GRB | BAO | YI, CO | ZI, ZLO | MARI, RD | MDRI, MDRO | GRA | RI};
      OP_ST: s = {GRB | BAO | YI, CO | ZI, ZLO | MARI, GRA | RO | MDRI, WR};
      OP_BR: s = {GRA | RO | CONI, PCO | YI, CO | ZI, ZLO | (c ? PCI : 32'd0)};
      OP_JR: s = {GRA | RO | PCI};
      OP_IN: s = {INPO | GRA | RI};
      OP_OUT: s = {GRA | RO | OUTI};
      OP_MFHI: s = {HIO | GRA | RI};
      OP_MFLO: s = {LOO | GRA | RI};
      default: s = {32'd0};
    endcase
    foreach (s[i]) seq.push_back(RUN | s[i]);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    sb.push_back(32'd0);
    cyc();
    sb.push_back(32'd0);
    cyc();
    rst_n = 1'b1;
    sb.push_back(32'd0);
  endtask
  task automatic run_instr(input logic [31:0] ir_v, input logic c);
    int n;
    cyc();
    bus.ir = ir_v;
    bus.con = c;
    build(ir_v[31:27], c);
    foreach (seq[i]) sb.push_back(seq[i]);
    n = seq.size();
    if (ir_v[31:27] == OP_HALT) begin
      repeat (20) sb.push_back(32'd0);
      n += 20;
    end
    repeat (n - 1) cyc();
    if (ir_v[31:27] == OP_HALT) begin
      cyc();
      do_reset();
    end
  endtask
  task automatic st_abort();
    cyc();
    bus.ir = {OP_ST, 27'h1234567};
    bus.con = 1'b0;
    build(OP_ST, 1'b0);
    for (int i = 0; i < 4; i++) sb.push_back(seq[i]);
    repeat (4) cyc();
    #2;
    chk("st_t4", obs, RUN | CO | ZI);
    rst_n = 1'b0;
    #1;
    chk("async_reset", obs, 32'd0);
    do_reset();
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("step", obs, e);
      chk("exclusive", {31'd0, (obs[26] & obs[25]) || ($countones(obs[9:0]) > 1)}, 32'd0);
    end
  initial begin
    bus.ir = 32'd0;
    bus.con = 1'b0;
    cyc();
    do_reset();
    run_instr(32'h18918000, 1'b0);
    run_instr({OP_LD, 27'h0ABCDEF}, 1'b1);
    run_instr({OP_BR, 27'h0123456}, 1'b1);
    run_instr({OP_BR, 27'h0123456}, 1'b0);
    run_instr({OP_ST, 27'h7654321}, 1'b1);
    run_instr({OP_SUB, 27'h5555555}, 1'b0);
    run_instr({OP_ORI, 27'h2AAAAAA}, 1'b1);
    st_abort();
    run_instr({OP_HALT, 27'd0}, 1'b0);
    for (int i = 0; i < 200; i++) run_instr($urandom, 1'($urandom_range(0, 1)));
    cyc();
    cyc();
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
